// File: rtl/circuit_pkg.sv
// Shared constants for the nodal-analysis flow: table geometry, element type
// codes and the choose_ref_node state encoding.
package circuit_pkg;

    localparam int unsigned MAX_ELEMENTS = 16;
    localparam int unsigned MAX_NODES    = 16;
    localparam int unsigned ADDR_W       = 4;
    localparam int unsigned NODE_W       = 4;
    localparam int unsigned CNT_W        = 6;

    localparam logic [1:0] ELEM_R     = 2'd0;
    localparam logic [1:0] ELEM_VSRC  = 2'd1;
    localparam logic [1:0] ELEM_ISRC  = 2'd2;
    localparam logic [1:0] ELEM_EMPTY = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_FETCH = 3'd2;
    localparam state_t ST_ACCUM = 3'd3;
    localparam state_t ST_SCAN  = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/degree_argmax.sv
// Per-node saturating degree counters plus a one-node-per-cycle argmax scan
// where the lowest index wins ties.
module degree_argmax
    import circuit_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_inc,
    input  logic [NODE_W-1:0] i_node_a,
    input  logic [NODE_W-1:0] i_node_b,
    input  logic [NODE_W:0]   i_num_nodes,
    input  logic              i_scan_step,
    input  logic [NODE_W-1:0] i_scan_idx,
    output logic [NODE_W-1:0] o_best
);

    logic [CNT_W-1:0]  r_count     [MAX_NODES];
    logic [CNT_W-1:0]  w_count_d   [MAX_NODES];
    logic [CNT_W:0]    w_sum       [MAX_NODES];
    logic [2:0]        w_inc       [MAX_NODES];
    logic              w_a_ok;
    logic              w_b_ok;
    logic              w_loop;

    logic [NODE_W-1:0] r_best;
    logic [NODE_W-1:0] w_best_d;
    logic [CNT_W-1:0]  r_best_cnt;
    logic [CNT_W-1:0]  w_best_cnt_d;
    logic [CNT_W-1:0]  w_cur;

    assign w_a_ok = {1'b0, i_node_a} < i_num_nodes;
    assign w_b_ok = {1'b0, i_node_b} < i_num_nodes;
    assign w_loop = w_a_ok && (i_node_a == i_node_b);

    // A self-loop adds two extra on top of its two terminals.
    always_comb begin
        for (int n = 0; n < MAX_NODES; n++) begin
            w_inc[n] = 3'd0;
            if (w_a_ok && i_node_a == NODE_W'(n)) w_inc[n] = w_inc[n] + 3'd1;
            if (w_b_ok && i_node_b == NODE_W'(n)) w_inc[n] = w_inc[n] + 3'd1;
            if (w_loop && i_node_a == NODE_W'(n)) w_inc[n] = w_inc[n] + 3'd2;
            w_sum[n]     = {1'b0, r_count[n]} + {{(CNT_W-2){1'b0}}, w_inc[n]};
            w_count_d[n] = w_sum[n][CNT_W] ? {CNT_W{1'b1}} : w_sum[n][CNT_W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            for (int n = 0; n < MAX_NODES; n++) r_count[n] <= '0;
        end else if (i_inc) begin
            for (int n = 0; n < MAX_NODES; n++) r_count[n] <= w_count_d[n];
        end
    end

    always_comb begin
        w_cur        = r_count[i_scan_idx];
        w_best_d     = r_best;
        w_best_cnt_d = r_best_cnt;
        if (i_scan_step) begin
            if (i_scan_idx == '0) begin
                w_best_d     = '0;
                w_best_cnt_d = w_cur;
            end else if (w_cur > r_best_cnt) begin
                w_best_d     = i_scan_idx;
                w_best_cnt_d = w_cur;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_best     <= '0;
            r_best_cnt <= '0;
        end else begin
            r_best     <= w_best_d;
            r_best_cnt <= w_best_cnt_d;
        end
    end

    // Includes the current step so the caller can latch on the final node.
    assign o_best = w_best_d;

endmodule

// File: rtl/choose_ref_node.sv
// Picks the highest-degree node as the circuit reference node.
// Optional CHOOSE_REF_VSRC_EN: prefer node_b of the first voltage source.
module choose_ref_node
    import circuit_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_program_reset,
    input  logic              i_run_chooseRefNode,
    input  logic [ADDR_W:0]   i_num_elements,
    input  logic [NODE_W:0]   i_num_nodes,
    output logic [ADDR_W-1:0] o_elem_addr,
    input  logic [1:0]        i_elem_type,
    input  logic [NODE_W-1:0] i_elem_node_a,
    input  logic [NODE_W-1:0] i_elem_node_b,
    output logic [NODE_W-1:0] o_ref_node,
    output logic              o_chooseRefNode_done
);

    state_t            r_state;
    state_t            w_state_d;
    logic [ADDR_W-1:0] r_idx;
    logic [NODE_W-1:0] r_scan_n;
    logic [NODE_W-1:0] r_ref_node;
    logic [NODE_W-1:0] w_best;
    logic [NODE_W-1:0] w_ref_d;
    logic [NODE_W:0]   w_num_nodes_eff;
    logic              w_last_elem;
    logic              w_last_node;
    logic              w_clear;
    logic              w_inc;
    logic              w_scan_step;
    logic              w_latch;

    assign w_num_nodes_eff = (i_num_nodes == '0) ? (NODE_W+1)'(1) : i_num_nodes;
    assign w_last_elem = ({1'b0, r_idx} + (ADDR_W+1)'(1)) == i_num_elements;
    assign w_last_node = ({1'b0, r_scan_n} + (NODE_W+1)'(1)) == w_num_nodes_eff;

    always_ff @(posedge i_clk) begin
        if (i_program_reset) r_state <= ST_IDLE;
        else                 r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE:  if (i_run_chooseRefNode) w_state_d = ST_CLEAR;
            ST_CLEAR: w_state_d = (i_num_elements == '0) ? ST_SCAN : ST_FETCH;
            ST_FETCH: w_state_d = ST_ACCUM;
            ST_ACCUM: w_state_d = w_last_elem ? ST_SCAN : ST_FETCH;
            ST_SCAN:  if (w_last_node) w_state_d = ST_DONE;
            ST_DONE:  w_state_d = ST_DONE;
            default:  w_state_d = ST_IDLE;
        endcase
        // Dropping run aborts from any state and also ends DONE.
        if (!i_run_chooseRefNode) w_state_d = ST_IDLE;
    end

    always_comb begin
        w_clear              = (r_state == ST_IDLE) || (r_state == ST_CLEAR);
        w_inc                = (r_state == ST_ACCUM) && (i_elem_type != ELEM_EMPTY);
        w_scan_step          = (r_state == ST_SCAN);
        w_latch              = w_scan_step && w_last_node && i_run_chooseRefNode;
        o_elem_addr          = (r_state == ST_FETCH) ? r_idx : '0;
        o_chooseRefNode_done = (r_state == ST_DONE);
        o_ref_node           = r_ref_node;
    end

    always_ff @(posedge i_clk) begin
        if (i_program_reset) begin
            r_idx      <= '0;
            r_scan_n   <= '0;
            r_ref_node <= '0;
        end else begin
            if (w_clear) begin
                r_idx    <= '0;
                r_scan_n <= '0;
            end
            if (r_state == ST_ACCUM) r_idx <= r_idx + ADDR_W'(1);
            if (w_scan_step)         r_scan_n <= r_scan_n + NODE_W'(1);
            if (w_latch)             r_ref_node <= w_ref_d;
        end
    end

    degree_argmax u_degree_argmax (
        .i_clk       (i_clk),
        .i_rst       (i_program_reset),
        .i_clear     (w_clear),
        .i_inc       (w_inc),
        .i_node_a    (i_elem_node_a),
        .i_node_b    (i_elem_node_b),
        .i_num_nodes (w_num_nodes_eff),
        .i_scan_step (w_scan_step),
        .i_scan_idx  (r_scan_n),
        .o_best      (w_best)
    );

`ifdef CHOOSE_REF_VSRC_EN
    logic              r_vsrc_valid;
    logic [NODE_W-1:0] r_vsrc_node;

    always_ff @(posedge i_clk) begin
        if (i_program_reset || w_clear) begin
            r_vsrc_valid <= 1'b0;
            r_vsrc_node  <= '0;
        end else if (r_state == ST_ACCUM && i_elem_type == ELEM_VSRC && !r_vsrc_valid) begin
            r_vsrc_valid <= 1'b1;
            r_vsrc_node  <= i_elem_node_b;
        end
    end

    assign w_ref_d = (r_vsrc_valid && ({1'b0, r_vsrc_node} < w_num_nodes_eff)) ?
                     r_vsrc_node : w_best;
`else
    assign w_ref_d = w_best;
`endif

endmodule
